nyq_fir_mc: RTL and testbench

Parametrised multi-channel Nyquist (raised-cosine) FIR filter with a run-time programmable coefficient RAM and a valid/ready sample interface. A single time-multiplexed MAC serves NUM_CH independent delay lines. Rounding and saturation are applied at the output. The block replaces the single-channel fixed-rate NYQ stage in the transmit pulse-shaping path.

---
 rtl/nyq_fir_mc.sv | 232 +++++++++++++++++++++++
 tb/tb_nyq_fir_mc.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nyq_fir_mc.sv
// -----------------------------------------------------------------------------
// nyq_fir_mc
//
// Multi-channel Nyquist (raised-cosine) FIR filter. One time-multiplexed MAC
// serves NUM_CH independent delay lines. It processes one tap per cycle. The
// coefficient RAM can be written at run time while the filter is idle. The
// accumulator keeps full precision. It is rounded half-up and saturated to
// OUT_WIDTH on the way out.
//
// Timing for a sample accepted at edge E0 with N = NTaps_DI + 1 taps:
//   E0+1 .. E0+N : MAC, one tap per edge
//   E0+N+1       : result registered; OutValid_SO high for the next cycle,
//                  InReady_SO high again, next acceptance possible at E0+N+2
//
// Ports
//   Clk_CI       in   clock, rising edge
//   Rst_RI       in   asynchronous active-high reset
//   WrEn_SI      in   coefficient write enable (honoured only when idle)
//   Addr_DI      in   coefficient index
//   PAR_In_DI    in   coefficient value, signed, FRAC_BITS fractional bits
//   NTaps_DI     in   active tap count minus one, latched at acceptance
//   InValid_SI   in   input sample valid
//   InCh_DI      in   input sample channel
//   NYQ_In_DI    in   input sample, signed
//   InReady_SO   out  block can accept a sample this cycle
//   OutValid_SO  out  one-cycle pulse, result available
//   OutCh_DO     out  channel of the current result
//   NYQ_Out_DO   out  filtered, rounded, saturated sample
//   Sat_SO       out  result was clipped; qualified by OutValid_SO
// -----------------------------------------------------------------------------
module nyq_fir_mc #(
  parameter  int ADDR_WIDTH = 5,
  parameter  int MEM_WIDTH  = 32,
  parameter  int FRAC_BITS  = 23,
  parameter  int IN_WIDTH   = 24,
  parameter  int OUT_WIDTH  = 24,
  parameter  int NUM_CH     = 2,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic [MEM_WIDTH-1:0]        PAR_In_DI,
  input  logic [ADDR_WIDTH-1:0]       NTaps_DI,
  input  logic                        InValid_SI,
  input  logic [CH_W-1:0]             InCh_DI,
  input  logic [IN_WIDTH-1:0]         NYQ_In_DI,
  output logic                        InReady_SO,
  output logic                        OutValid_SO,
  output logic [CH_W-1:0]             OutCh_DO,
  output logic signed [OUT_WIDTH-1:0] NYQ_Out_DO,
  output logic                        Sat_SO
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int PROD_W = IN_WIDTH + MEM_WIDTH;
  localparam int ACC_W  = IN_WIDTH + MEM_WIDTH + ADDR_WIDTH;

  // Half an LSB of the output, added before the arithmetic shift (round half up).
  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic signed [MEM_WIDTH-1:0]  r_coef [DEPTH];
  logic signed [IN_WIDTH-1:0]   r_dl   [NUM_CH][DEPTH];
  logic [ADDR_WIDTH-1:0]        r_ptr  [NUM_CH];

  logic signed [ACC_W-1:0]      r_acc;
  logic [CH_W-1:0]              r_ch;
  logic [ADDR_WIDTH-1:0]        r_ntaps;
  logic [ADDR_WIDTH-1:0]        r_k;

  logic                         r_out_valid;
  logic [CH_W-1:0]              r_out_ch;
  logic signed [OUT_WIDTH-1:0]  r_out;
  logic                         r_sat;

  logic                         w_idle;
  logic                         w_coef_we;
  logic                         w_accept;
  logic                         w_last_tap;
  logic [ADDR_WIDTH-1:0]        w_rd_idx;
  logic signed [PROD_W-1:0]     w_coef_ext;
  logic signed [PROD_W-1:0]     w_samp_ext;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_prod_ext;
  logic signed [ACC_W-1:0]      w_rnd;
  logic signed [ACC_W-1:0]      w_shift;
  logic signed [OUT_WIDTH-1:0]  w_y;
  logic                         w_sat;

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  // A coefficient write has priority over a sample in the same idle cycle.
  // Ready is dropped so the upstream sample waits.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_coef_we  = w_idle & WrEn_SI;
  assign w_accept   = w_idle & ~WrEn_SI & InValid_SI;
  assign w_last_tap = (r_k == r_ntaps);
  assign InReady_SO = w_idle & ~WrEn_SI;

  // ---------------------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------------------
  // Tap k reads the sample written k acceptances ago on this channel. The
  // ADDR_WIDTH-bit subtraction gives the mod-DEPTH wrap for free.
  assign w_rd_idx   = r_ptr[r_ch] - r_k;
  assign w_coef_ext = PROD_W'(r_coef[r_k]);
  assign w_samp_ext = PROD_W'(r_dl[r_ch][w_rd_idx]);
  assign w_prod     = w_coef_ext * w_samp_ext;
  assign w_prod_ext = ACC_W'(w_prod);

  // ---------------------------------------------------------------------------
  // Output rounding and saturation
  // ---------------------------------------------------------------------------
  assign w_rnd   = r_acc + RND_HALF;
  assign w_shift = w_rnd >>> FRAC_BITS;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_y   = w_shift[OUT_WIDTH-1:0];
    w_sat = 1'b0;
    if (w_shift > OUT_MAX) begin
      w_y   = OUT_MAX[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_shift < OUT_MIN) begin
      w_y   = OUT_MIN[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_MAC;
      ST_MAC:  if (w_last_tap) w_state_nxt = ST_OUT;
      ST_OUT:                  w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, storage and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here, so every register samples values from
  // before the edge no matter what order the statements are in.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state     <= ST_IDLE;
      // NOTE: the coefficient RAM and delay lines must read back as zero after
      // reset. They are therefore built from resettable flops, not from an
      // inferred RAM macro.
      for (int a = 0; a < DEPTH; a++) begin
        r_coef[a] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        r_ptr[c] <= '0;
        for (int a = 0; a < DEPTH; a++) begin
          r_dl[c][a] <= '0;
        end
      end
      r_acc       <= '0;
      r_ch        <= '0;
      r_ntaps     <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out       <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_coef_we) begin
            r_coef[Addr_DI] <= PAR_In_DI;
          end else if (w_accept) begin
            // Newest sample goes in at the current pointer. The pointer only
            // advances once the MAC is done, so tap 0 reads this sample.
            r_dl[InCh_DI][r_ptr[InCh_DI]] <= NYQ_In_DI;
            r_ch    <= InCh_DI;
            r_ntaps <= NTaps_DI;
            r_acc   <= '0;
            r_k     <= '0;
          end
        end

        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + ADDR_WIDTH'(1);
          if (w_last_tap) begin
            r_ptr[r_ch] <= r_ptr[r_ch] + ADDR_WIDTH'(1);
          end
        end

        ST_OUT: begin
          r_out_valid <= 1'b1;
          r_out       <= w_y;
          r_sat       <= w_sat;
          r_out_ch    <= r_ch;
        end

        default: ;
      endcase
    end
  end

  assign OutValid_SO = r_out_valid;
  assign OutCh_DO    = r_out_ch;
  assign NYQ_Out_DO  = r_out;
  assign Sat_SO      = r_sat;

endmodule

// File: tb/tb_nyq_fir_mc.sv
// -----------------------------------------------------------------------------
// tb_nyq_fir_mc
//
// Self-checking bench for nyq_fir_mc. It has two parts:
//   - A table of {channel, input, expected output, expected sat} vectors for
//     the impulse, channel-isolation and rounding/saturation cases.
//   - Hand-written sequences for the reset, busy-write and wrap corner cases,
//     plus randomized traffic. The random traffic is compared against a
//     shift-register and plain-sum reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_nyq_fir_mc;

  localparam int AW    = 5;
  localparam int MW    = 32;
  localparam int FB    = 23;
  localparam int IW    = 24;
  localparam int OW    = 24;
  localparam int NCH   = 2;
  localparam int CW    = 1;
  localparam int DEPTH = 32;

  localparam longint OUT_MAX = (longint'(1) <<< (OW-1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) <<< (OW-1));

  logic                 Clk_CI     = 1'b0;
  logic                 Rst_RI     = 1'b1;
  logic                 WrEn_SI    = 1'b0;
  logic [AW-1:0]        Addr_DI    = '0;
  logic [MW-1:0]        PAR_In_DI  = '0;
  logic [AW-1:0]        NTaps_DI   = '0;
  logic                 InValid_SI = 1'b0;
  logic [CW-1:0]        InCh_DI    = '0;
  logic [IW-1:0]        NYQ_In_DI  = '0;
  logic                 InReady_SO;
  logic                 OutValid_SO;
  logic [CW-1:0]        OutCh_DO;
  logic signed [OW-1:0] NYQ_Out_DO;
  logic                 Sat_SO;

  nyq_fir_mc #(
    .ADDR_WIDTH (AW),
    .MEM_WIDTH  (MW),
    .FRAC_BITS  (FB),
    .IN_WIDTH   (IW),
    .OUT_WIDTH  (OW),
    .NUM_CH     (NCH)
  ) dut (
    .Clk_CI      (Clk_CI),
    .Rst_RI      (Rst_RI),
    .WrEn_SI     (WrEn_SI),
    .Addr_DI     (Addr_DI),
    .PAR_In_DI   (PAR_In_DI),
    .NTaps_DI    (NTaps_DI),
    .InValid_SI  (InValid_SI),
    .InCh_DI     (InCh_DI),
    .NYQ_In_DI   (NYQ_In_DI),
    .InReady_SO  (InReady_SO),
    .OutValid_SO (OutValid_SO),
    .OutCh_DO    (OutCh_DO),
    .NYQ_Out_DO  (NYQ_Out_DO),
    .Sat_SO      (Sat_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Each channel's history is a plain shift register: index 0
  // is the newest sample. The output is the direct sum over the active taps,
  // then rounded and clipped.
  // ---------------------------------------------------------------------------
  longint m_coef [DEPTH];
  longint m_hist [NCH][DEPTH];

  function automatic void model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      m_coef[a] = 0;
      for (int c = 0; c < NCH; c++) m_hist[c][a] = 0;
    end
  endfunction

  function automatic void model_step(input int ch, input longint x, input int ntaps,
                                     output longint y, output bit s);
    longint acc;
    for (int k = DEPTH-1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
    m_hist[ch][0] = x;
    acc = 0;
    for (int k = 0; k <= ntaps; k++) acc += m_coef[k] * m_hist[ch][k];
    y = (acc + (longint'(1) <<< (FB-1))) >>> FB;
    s = 1'b0;
    if (y > OUT_MAX) begin
      y = OUT_MAX;
      s = 1'b1;
    end else if (y < OUT_MIN) begin
      y = OUT_MIN;
      s = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers. Every task starts and ends just after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic do_reset(input string tag);
    InValid_SI = 1'b0;
    WrEn_SI    = 1'b0;
    Rst_RI     = 1'b1;
    #1;
    check($sformatf("%s_rst_valid", tag), OutValid_SO, 0);
    check($sformatf("%s_rst_ready", tag), InReady_SO, 1);
    check($sformatf("%s_rst_ch", tag), OutCh_DO, 0);
    check($sformatf("%s_rst_out", tag), longint'(NYQ_Out_DO), 0);
    check($sformatf("%s_rst_sat", tag), Sat_SO, 0);
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    model_clear();
  endtask

  task automatic wr_coef(input int a, input logic [MW-1:0] v);
    WrEn_SI   = 1'b1;
    Addr_DI   = a[AW-1:0];
    PAR_In_DI = v;
    @(posedge Clk_CI);
    @(negedge Clk_CI);
    WrEn_SI   = 1'b0;
    m_coef[a] = longint'($signed(v));
  endtask

  // Offer one sample and wait for its result. busy_wr fires an attempted
  // write of zero to coef[0] during the first MAC cycle.
  task automatic run_sample(input int ch, input longint x, input bit busy_wr,
                            output longint y, output bit s, output int och,
                            output longint my, output bit ms);
    int lat;
    int nt;
    nt         = int'(NTaps_DI);
    InCh_DI    = ch[CW-1:0];
    NYQ_In_DI  = x[IW-1:0];
    InValid_SI = 1'b1;
    #1;
    check("ready_idle", InReady_SO, 1);
    @(posedge Clk_CI);
    model_step(ch, x, nt, my, ms);
    @(negedge Clk_CI);
    InValid_SI = 1'b0;
    check("ready_busy", InReady_SO, 0);
    if (busy_wr) begin
      WrEn_SI   = 1'b1;
      Addr_DI   = '0;
      PAR_In_DI = '0;
    end
    lat = 0;
    while (lat < 200) begin
      @(posedge Clk_CI);
      lat++;
      @(negedge Clk_CI);
      WrEn_SI = 1'b0;
      if (OutValid_SO) break;
    end
    // OutValid_SO rises at edge E0+N+1, i.e. N+1 = NTaps_DI+2 edges after acceptance.
    check("latency_edges", lat, nt + 2);
    check("ready_at_out", InReady_SO, 1);
    y   = longint'(NYQ_Out_DO);
    s   = Sat_SO;
    och = int'(OutCh_DO);
    @(negedge Clk_CI);
    check("valid_pulse_width", OutValid_SO, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int     ch;
    longint x;
    longint y;
    bit     sat;
  } vec_t;

  vec_t vt [19];

  task automatic apply_vec(input int i);
    longint y, my;
    bit     s, ms;
    int     och;
    run_sample(vt[i].ch, vt[i].x, 1'b0, y, s, och, my, ms);
    check($sformatf("vec%0d_y", i), y, vt[i].y);
    check($sformatf("vec%0d_sat", i), s, vt[i].sat);
    check($sformatf("vec%0d_ch", i), och, vt[i].ch);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint    y, my;
    bit        s, ms;
    int        och;
    int        seen;
    logic [IW-1:0]        rx;
    logic signed [MW-1:0] rc;

    // Impulse response 1,2,3,4 then history clears out.
    vt[0]  = '{0, 1, 1, 1'b0};
    vt[1]  = '{0, 0, 2, 1'b0};
    vt[2]  = '{0, 0, 3, 1'b0};
    vt[3]  = '{0, 0, 4, 1'b0};
    vt[4]  = '{0, 0, 0, 1'b0};
    // Interleaved ch0 impulse 100 and ch1 constant 10.
    vt[5]  = '{0, 100, 100, 1'b0};
    vt[6]  = '{1, 10,  10,  1'b0};
    vt[7]  = '{0, 0,   200, 1'b0};
    vt[8]  = '{1, 10,  30,  1'b0};
    vt[9]  = '{0, 0,   300, 1'b0};
    vt[10] = '{1, 10,  60,  1'b0};
    vt[11] = '{0, 0,   400, 1'b0};
    vt[12] = '{1, 10,  100, 1'b0};
    vt[13] = '{0, 0,   0,   1'b0};
    vt[14] = '{1, 10,  100, 1'b0};
    // coef 0.5: round half up.
    vt[15] = '{0, 3,  2,  1'b0};
    vt[16] = '{0, -3, -1, 1'b0};
    // coef 2.0: clip at both rails.
    vt[17] = '{0, 64'sh600000,  8388607,  1'b1};
    vt[18] = '{0, -64'sh600000, -8388608, 1'b1};

    @(negedge Clk_CI);
    do_reset("init");

    // ---- impulse ----
    for (int k = 0; k < 4; k++) wr_coef(k, MW'((k + 1) << FB));
    NTaps_DI = 3;
    for (int i = 0; i <= 4; i++) apply_vec(i);

    // ---- write with simultaneous valid: sample must not be taken ----
    WrEn_SI    = 1'b1;
    Addr_DI    = 5'd10;
    PAR_In_DI  = 32'h123;
    InCh_DI    = '0;
    NYQ_In_DI  = 24'd99;
    InValid_SI = 1'b1;
    #1;
    check("ready_during_write", InReady_SO, 0);
    @(posedge Clk_CI);
    @(negedge Clk_CI);
    WrEn_SI    = 1'b0;
    InValid_SI = 1'b0;
    m_coef[10] = 64'h123;
    seen = 0;
    repeat (8) begin
      @(negedge Clk_CI);
      if (OutValid_SO) seen++;
    end
    check("write_blocks_sample", seen, 0);

    // ---- busy write: coef[0] must survive ----
    NTaps_DI = 3;
    run_sample(0, 1, 1'b1, y, s, och, my, ms);
    check("busy_wr_y", y, 1);
    // This sample was accepted after the ignored write, so it must still see
    // coef[0] = 1.0.
    run_sample(1, 1, 1'b0, y, s, och, my, ms);
    check("after_busy_wr_y", y, 1);
    check("after_busy_wr_model", y, my);
    check("after_busy_wr_ch", och, 1);

    // ---- reset during MAC ----
    InCh_DI    = '0;
    NYQ_In_DI  = 24'd7;
    InValid_SI = 1'b1;
    @(posedge Clk_CI);
    @(negedge Clk_CI);
    InValid_SI = 1'b0;
    @(negedge Clk_CI);
    do_reset("mid");
    seen = 0;
    repeat (12) begin
      @(negedge Clk_CI);
      if (OutValid_SO) seen++;
    end
    check("aborted_no_valid", seen, 0);
    // Coefficients are zero after reset, so an impulse gives zero.
    NTaps_DI = 3;
    run_sample(0, 1000, 1'b0, y, s, och, my, ms);
    check("zero_coef_y", y, 0);

    // ---- channel isolation ----
    do_reset("iso");
    for (int k = 0; k < 4; k++) wr_coef(k, MW'((k + 1) << FB));
    NTaps_DI = 3;
    for (int i = 5; i <= 14; i++) apply_vec(i);

    // ---- rounding and saturation ----
    do_reset("rnd");
    wr_coef(0, 32'h0040_0000);
    NTaps_DI = 0;
    apply_vec(15);
    apply_vec(16);
    wr_coef(0, 32'h0100_0000);
    apply_vec(17);
    apply_vec(18);

    // ---- full depth and pointer wrap ----
    do_reset("wrap");
    wr_coef(31, MW'(1 << FB));
    NTaps_DI = 5'd31;
    for (int n = 1; n <= 40; n++) begin
      run_sample(1, n, 1'b0, y, s, och, my, ms);
      check($sformatf("wrap_n%0d", n), y, (n >= 32) ? longint'(n - 31) : 0);
    end

    // ---- randomized traffic against the model ----
    do_reset("rand");
    for (int a = 0; a < DEPTH; a++) begin
      rc = $signed($urandom) >>> $urandom_range(0, 12);
      wr_coef(a, rc);
    end
    for (int i = 0; i < 40; i++) begin
      NTaps_DI = AW'($urandom_range(0, DEPTH - 1));
      rx = IW'($urandom);
      run_sample(int'($urandom_range(0, NCH - 1)), longint'($signed(rx)), 1'b0,
                 y, s, och, my, ms);
      check($sformatf("rand%0d_y", i), y, my);
      check($sformatf("rand%0d_sat", i), s, ms);
      check($sformatf("rand%0d_ch", i), och, int'(InCh_DI));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
